// File: rtl/demux_rr_scheduler_pkg.sv
// Shared types and helpers for the round-robin 1-to-8 demux scheduler.
// Lane search wraps 7 -> 0; an empty mask returns the start lane unchanged.
package demux_pkg;

   localparam int NUM_LANES = 8;
   localparam int SEL_W     = 3;

   typedef enum logic [0:0] {
      EMPTY = 1'b0,
      HOLD  = 1'b1
   } state_e;

   function automatic logic [NUM_LANES-1:0] onehot8(input logic [SEL_W-1:0] sel);
      onehot8 = 8'h01 << sel;
   endfunction

   function automatic logic [SEL_W-1:0] next_enabled(input logic [NUM_LANES-1:0] mask,
                                                      input logic [SEL_W-1:0]     start);
      logic [SEL_W-1:0] idx;
      logic             found;
      next_enabled = start;
      found        = 1'b0;
      for (int i = 0; i < NUM_LANES; i++) begin
         idx = start + i[SEL_W-1:0];
         if (!found && mask[idx]) begin
            next_enabled = idx;
            found        = 1'b1;
         end else begin
            found = found;
         end
      end
   endfunction

endpackage

// File: rtl/demux_rr_scheduler_if.sv
// Input stream, lane outputs and status of the demux scheduler.
// The slave modport is the scheduler side; master is the surrounding datapath.
interface demux_rr_scheduler_if #(parameter int W = 8);
   import demux_pkg::*;

   logic                 in_valid;
   logic [W-1:0]         in_data;
   logic                 in_ready;
   logic [NUM_LANES-1:0] en_mask;
   logic [NUM_LANES-1:0] out_valid;
   logic [W-1:0]         out_data;
   logic [NUM_LANES-1:0] out_ready;
   logic [SEL_W-1:0]     cur_sel;
   logic                 busy;

   modport master (
      output in_valid, in_data, en_mask, out_ready,
      input  in_ready, out_valid, out_data, cur_sel, busy
   );

   modport slave (
      input  in_valid, in_data, en_mask, out_ready,
      output in_ready, out_valid, out_data, cur_sel, busy
   );

endinterface

// File: rtl/demux_rr_scheduler_pick.sv
// Rotating priority picker: first enabled lane at or after i_start, with wrap.
module demux_rr_pick
   import demux_pkg::*;
(
   input  logic [NUM_LANES-1:0] i_mask,
   input  logic [SEL_W-1:0]     i_start,
   output logic [SEL_W-1:0]     o_lane,
   output logic                 o_any
);

   // Search result and "some lane is enabled" flag.
   always_comb begin
      o_lane = next_enabled(i_mask, i_start);
      o_any  = |i_mask;
   end

endmodule

// File: rtl/demux_rr_scheduler.sv
// Round-robin sequencer for the 1-to-8 demux: bursts of BURST items per lane,
// skipping disabled lanes, with a single output holding stage.
module demux_rr_scheduler
   import demux_pkg::*;
#(
   parameter int W     = 8,
   parameter int BURST = 4
)(
   input  logic                  clk,
   input  logic                  rst_n,
   demux_rr_scheduler_if.slave   bus
);

   localparam logic [7:0] BURST_C = 8'(BURST);

   state_e               r_state;
   logic [NUM_LANES-1:0] r_out_valid;
   logic [W-1:0]         r_out_data;
   logic [SEL_W-1:0]     r_hsel;
   logic [SEL_W-1:0]     r_ptr;
   logic [7:0]           r_cnt;

   logic [SEL_W-1:0]     w_tgt;
   logic [SEL_W-1:0]     w_tgt_inc;
   logic [SEL_W-1:0]     w_adv;
   logic                 w_any;
   logic                 w_any_adv;
   logic                 w_busy;
   logic                 w_out_fire;
   logic                 w_in_ready;
   logic                 w_in_fire;
   logic [7:0]           w_cnt_base;
   logic [7:0]           w_cnt_inc;

   demux_rr_pick u_pick_tgt (
      .i_mask  (bus.en_mask),
      .i_start (r_ptr),
      .o_lane  (w_tgt),
      .o_any   (w_any)
   );

   // Burst advance looks for the next enabled lane strictly after the target.
   assign w_tgt_inc = w_tgt + 3'd1;

   demux_rr_pick u_pick_adv (
      .i_mask  (bus.en_mask),
      .i_start (w_tgt_inc),
      .o_lane  (w_adv),
      .o_any   (w_any_adv)
   );

   assign w_busy     = (r_state == HOLD);
   assign w_out_fire = w_busy & bus.out_ready[r_hsel];
   assign w_in_ready = w_any & (~w_busy | w_out_fire);
   assign w_in_fire  = bus.in_valid & w_in_ready;

   // A skipped lane restarts the burst count from the new target.
   always_comb begin
      if (w_tgt != r_ptr) begin
         w_cnt_base = 8'd0;
      end else begin
         w_cnt_base = r_cnt;
      end
      w_cnt_inc = w_cnt_base + 8'd1;
   end

   // Holding stage: load on accept, release on lane accept, otherwise stay frozen.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= EMPTY;
         r_out_valid <= 8'h00;
         r_out_data  <= {W{1'b0}};
         r_hsel      <= 3'd0;
      end else begin
         case (r_state)
            EMPTY: begin
               if (w_in_fire) begin
                  r_state     <= HOLD;
                  r_out_data  <= bus.in_data;
                  r_out_valid <= onehot8(w_tgt);
                  r_hsel      <= w_tgt;
               end else begin
                  r_state <= EMPTY;
               end
            end
            HOLD: begin
               if (w_in_fire) begin
                  r_out_data  <= bus.in_data;
                  r_out_valid <= onehot8(w_tgt);
                  r_hsel      <= w_tgt;
               end else if (w_out_fire) begin
                  r_state     <= EMPTY;
                  r_out_valid <= 8'h00;
               end else begin
                  r_state <= HOLD;
               end
            end
            default: begin
               r_state     <= EMPTY;
               r_out_valid <= 8'h00;
            end
         endcase
      end
   end

   // Lane pointer and burst counter move only when an item is accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= 3'd0;
         r_cnt <= 8'd0;
      end else if (w_in_fire) begin
         if (w_cnt_inc == BURST_C) begin
            r_cnt <= 8'd0;
            r_ptr <= w_any_adv ? w_adv : w_tgt;
         end else begin
            r_cnt <= w_cnt_inc;
            r_ptr <= w_tgt;
         end
      end else begin
         r_cnt <= r_cnt;
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.cur_sel   = w_tgt;
   assign bus.busy      = w_busy;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;

endmodule
